// File: rtl/gaussian_filter_pkg.sv
// Shared types and constants for the streaming 3x3 smoothing filter.
package gaussian_filter_pkg;

  typedef enum logic [1:0] {
    GF_FILL0 = 2'd0,
    GF_FILL1 = 2'd1,
    GF_FILL2 = 2'd2,
    GF_FULL  = 2'd3
  } gf_state_e;

  localparam logic GF_MODE_GAUSS = 1'b0;
  localparam logic GF_MODE_PLUS  = 1'b1;

  localparam int GF_SHIFT_GAUSS = 4;
  localparam int GF_SHIFT_PLUS  = 3;

  localparam int GF_RND_GAUSS = 8;
  localparam int GF_RND_PLUS  = 4;

endpackage

// File: rtl/gf_col_sum.sv
// Vertical weighting of one pixel column for both kernels.
// Both sums fit in DW+3 bits: the worst case is 6 * (2^DW - 1).
module gf_col_sum #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] top,
  input  logic [DW-1:0] mid,
  input  logic [DW-1:0] bot,
  output logic [DW+2:0] gauss_sum,
  output logic [DW+2:0] plus_sum
);

  always_comb begin
    gauss_sum = {3'b000, top} + {2'b00, mid, 1'b0} + {3'b000, bot};
    plus_sum  = {3'b000, top} + {1'b0, mid, 2'b00} + {3'b000, bot};
  end

endmodule

// File: rtl/gaussian_filter_stream.sv
// Streaming 3x3 gaussian / plus filter fed one column per accepted cycle.
// Build option: define GAUSSIAN_ROUND_EN to round to nearest instead of truncating.
//
// state    | meaning
// GF_FILL0 | no columns of the current line held
// GF_FILL1 | one column held
// GF_FILL2 | two columns held; next acceptance produces a result
// GF_FULL  | window full; every acceptance produces a result
module gaussian_filter_stream
  import gaussian_filter_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          sol_i,
  input  logic          mode_i,
  input  logic [DW-1:0] d1_i,
  input  logic [DW-1:0] d2_i,
  input  logic [DW-1:0] d3_i,
  output logic          done_o,
  output logic [DW-1:0] gaussian_o,
  output logic          mode_o
);

  gf_state_e state_q, state_d;
  logic      acc_out;
  logic      first_col;

  logic [DW+2:0] col_g, col_p;
  // Two held columns plus the incoming one form the 3-column window,
  // which gives a single cycle of latency from the completing column.
  logic [DW+2:0] l_g_q, c_g_q, c_p_q;
  logic [DW-1:0] l_m_q, c_m_q;
  logic [DW+3:0] hsum_g, hsum_p;
  logic [DW-1:0] res;

  gf_col_sum #(.DW(DW)) u_col_sum (
    .top       (d1_i),
    .mid       (d2_i),
    .bot       (d3_i),
    .gauss_sum (col_g),
    .plus_sum  (col_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= GF_FILL0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    acc_out   = 1'b0;
    first_col = 1'b0;
    if (sol_i) begin
      state_d   = en_i ? GF_FILL1 : GF_FILL0;
      first_col = en_i;
    end else if (en_i) begin
      case (state_q)
        GF_FILL0: begin
          state_d   = GF_FILL1;
          first_col = 1'b1;
        end
        GF_FILL1: state_d = GF_FILL2;
        GF_FILL2: begin
          state_d = GF_FULL;
          acc_out = 1'b1;
        end
        default: begin
          state_d = GF_FULL;
          acc_out = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    hsum_g = {1'b0, l_g_q} + {c_g_q, 1'b0} + {1'b0, col_g};
    hsum_p = {4'b0000, l_m_q} + {1'b0, c_p_q} + {4'b0000, d2_i};
`ifdef GAUSSIAN_ROUND_EN
    hsum_g = hsum_g + (DW+4)'(GF_RND_GAUSS);
    hsum_p = hsum_p + (DW+4)'(GF_RND_PLUS);
`endif
    if (mode_o == GF_MODE_PLUS) res = DW'(hsum_p >> GF_SHIFT_PLUS);
    else                        res = DW'(hsum_g >> GF_SHIFT_GAUSS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_g_q <= '0;
      l_m_q <= '0;
      c_g_q <= '0;
      c_p_q <= '0;
      c_m_q <= '0;
    end else if (sol_i) begin
      l_g_q <= '0;
      l_m_q <= '0;
      c_g_q <= en_i ? col_g : '0;
      c_p_q <= en_i ? col_p : '0;
      c_m_q <= en_i ? d2_i  : '0;
    end else if (en_i) begin
      l_g_q <= c_g_q;
      l_m_q <= c_m_q;
      c_g_q <= col_g;
      c_p_q <= col_p;
      c_m_q <= d2_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_o     <= 1'b0;
      gaussian_o <= '0;
      mode_o     <= GF_MODE_GAUSS;
    end else begin
      done_o <= acc_out;
      if (acc_out)   gaussian_o <= res;
      if (first_col) mode_o     <= mode_i;
    end
  end

endmodule
